// File: rtl/rr_or_arbiter_ctrl_if.sv
// Bundle of requester-side and downstream-side signals for the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface rr_or_arbiter_ctrl_if #(
  parameter int NUM_INPUT_DATA = 8,
  parameter int DATA_WIDTH     = 16
);
  logic                                 i_en;
  logic [NUM_INPUT_DATA-1:0]            i_valid;
  logic [NUM_INPUT_DATA-1:0]            i_last;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus;
  logic [NUM_INPUT_DATA-1:0]            o_ready;
  logic                                 o_valid;
  logic [DATA_WIDTH-1:0]                o_data_bus;
  logic                                 i_ready;
  logic [NUM_INPUT_DATA-1:0]            o_grant;
  logic                                 o_busy;

  modport slave (
    input  i_en, i_valid, i_last, i_data_bus, i_ready,
    output o_ready, o_valid, o_data_bus, o_grant, o_busy
  );

  modport master (
    output i_en, i_valid, i_last, i_data_bus, i_ready,
    input  o_ready, o_valid, o_data_bus, o_grant, o_busy
  );
endinterface

// File: rtl/rr_or_arbiter_ctrl.sv
// Round-robin arbiter sharing one output channel among NUM_INPUT_DATA requesters.
// A grant is held for a whole packet or MAX_HOLD beats, then one idle bubble precedes the next grant.
module rr_or_arbiter_ctrl #(
  parameter int NUM_INPUT_DATA = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_HOLD       = 4
) (
  input logic                clk,
  input logic                rst,
  rr_or_arbiter_ctrl_if.slave bus
);
  localparam int N  = NUM_INPUT_DATA;
  localparam int DW = DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   beatCnt_q;

  logic [PW-1:0]   selIdx_d;
  logic [PW-1:0]   ptr_d;
  logic [CW-1:0]   beatCnt_d;
  logic            selFound;
  int              cand;
  logic            anyReq;
  logic            locked;
  logic            lockValid;
  logic            xfer;
  logic            holdHit;
  logic            doRelease;

  assign anyReq = |bus.i_valid;
  assign locked = (state_q == LOCK);

  // Scan upward from ptr with wrap; the first valid requester found wins.
  always_comb begin
    selIdx_d = ptr_q;
    selFound = 1'b0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!selFound && bus.i_valid[cand]) begin
        selFound = 1'b1;
        selIdx_d = PW'(cand);
      end
    end
  end

  assign lockValid = locked & bus.i_en & bus.i_valid[gidx_q];
  assign xfer      = lockValid & bus.i_ready;
  assign holdHit   = (MAX_HOLD != 0) && ((int'(beatCnt_q) + 1) == MAX_HOLD);
  assign doRelease = xfer & (bus.i_last[gidx_q] | holdHit);
  assign ptr_d     = (int'(gidx_q) == N - 1) ? '0 : gidx_q + 1'b1;
  assign beatCnt_d = beatCnt_q + 1'b1;

  assign bus.o_valid    = lockValid;
  assign bus.o_ready    = (locked && bus.i_en && bus.i_ready) ? grant_q : '0;
  assign bus.o_data_bus = locked ? bus.i_data_bus[gidx_q*DW +: DW] : '0;
  assign bus.o_grant    = grant_q;
  assign bus.o_busy     = locked;

  // A last beat that also hits the hold limit takes the single release path below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      beatCnt_q <= '0;
    end else if (bus.i_en) begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q   <= LOCK;
            gidx_q    <= selIdx_d;
            grant_q   <= {{(N-1){1'b0}}, 1'b1} << selIdx_d;
            beatCnt_q <= '0;
          end
        end
        LOCK: begin
          if (doRelease) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= ptr_d;
            beatCnt_q <= '0;
          end else if (xfer) begin
            beatCnt_q <= beatCnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_or_arbiter_ctrl.sv
// Self-checking bench for rr_or_arbiter_ctrl: directed scenarios followed by a random run,
// all compared cycle by cycle against a packet-level reference model.
module tb_rr_or_arbiter_ctrl;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int MH = 4;

  logic clk;
  logic rst;
  logic [N*DW-1:0] dataDrv;
  logic [N-1:0]    lastGrant;

  int checks;
  int failures;

  // Reference model: index of the granted requester (-1 when idle), scan start, beats in this grant.
  int mGrant;
  int mPtr;
  int mBeats;

  rr_or_arbiter_ctrl_if #(.NUM_INPUT_DATA(N), .DATA_WIDTH(DW)) bus ();

  rr_or_arbiter_ctrl #(
    .NUM_INPUT_DATA(N),
    .DATA_WIDTH    (DW),
    .MAX_HOLD      (MH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, then advance the model at the edge.
  task automatic applyStimulus(input logic rstV, input logic en, input logic [N-1:0] valid,
                               input logic [N-1:0] last, input logic ready);
    logic [N-1:0]  expGrant;
    logic [N-1:0]  expReady;
    logic          expValid;
    logic [DW-1:0] expData;
    @(negedge clk);
    rst            = rstV;
    bus.i_en       = en;
    bus.i_valid    = valid;
    bus.i_last     = last;
    bus.i_ready    = ready;
    bus.i_data_bus = dataDrv;
    #1;
    expGrant = '0;
    expReady = '0;
    expValid = 1'b0;
    expData  = '0;
    if (mGrant >= 0) begin
      expGrant[mGrant] = 1'b1;
      expValid = en && valid[mGrant];
      if (en && ready) expReady[mGrant] = 1'b1;
      expData = dataDrv[mGrant*DW +: DW];
    end
    checkOutput("grant", 32'(bus.o_grant), 32'(expGrant));
    checkOutput("busy",  32'(bus.o_busy),  32'(mGrant >= 0));
    checkOutput("valid", 32'(bus.o_valid), 32'(expValid));
    checkOutput("ready", 32'(bus.o_ready), 32'(expReady));
    checkOutput("data",  32'(bus.o_data_bus), 32'(expData));
    lastGrant = bus.o_grant;
    @(posedge clk);
    if (rstV) begin
      mGrant = -1;
      mPtr   = 0;
      mBeats = 0;
    end else if (en) begin
      if (mGrant < 0) begin
        for (int k = 0; k < N; k++) begin
          if (mGrant < 0 && valid[(mPtr + k) % N]) begin
            mGrant = (mPtr + k) % N;
            mBeats = 0;
          end
        end
      end else if (valid[mGrant] && ready) begin
        mBeats++;
        if (last[mGrant] || (MH != 0 && mBeats == MH)) begin
          mPtr   = (mGrant + 1) % N;
          mGrant = -1;
          mBeats = 0;
        end
      end
    end
  endtask

  task automatic setSlice(input int k, input logic [DW-1:0] v);
    dataDrv[k*DW +: DW] = v;
  endtask

  initial begin
    logic [N-1:0] rrExp [8];
    logic [N-1:0] holdExp [11];
    int readyPat [5];
    int beat;

    checks   = 0;
    failures = 0;
    mGrant   = -1;
    mPtr     = 0;
    mBeats   = 0;
    rst      = 1'b1;
    bus.i_en = 1'b0;
    bus.i_valid = '0;
    bus.i_last  = '0;
    bus.i_ready = 1'b0;
    for (int k = 0; k < N; k++) setSlice(k, DW'(16'h1000 + k));
    bus.i_data_bus = dataDrv;

    // Reset held with every requester asking; first grant lands one cycle after release of reset.
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    checkOutput("rst_grant_zero", 32'(lastGrant), 32'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    checkOutput("rst_first_grant", 32'(lastGrant), 32'h01);

    // Round robin among requesters 1, 4 and 7 with single-beat packets.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    rrExp = '{8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00, 8'h02};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'b1001_0010, 8'hFF, 1'b1);
      checkOutput($sformatf("rr_grant_%0d", i), 32'(lastGrant), 32'(rrExp[i]));
    end

    // Backpressure: three-beat packet from requester 2 with a toggling downstream ready.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    readyPat = '{1, 0, 1, 0, 1};
    beat = 0;
    setSlice(2, 16'h3000);
    applyStimulus(1'b0, 1'b1, 8'h04, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h04, (beat == 2) ? 8'h04 : 8'h00, readyPat[i] != 0);
      checkOutput($sformatf("bp_grant_%0d", i), 32'(lastGrant), 32'h04);
      if (readyPat[i] != 0) begin
        beat++;
        setSlice(2, DW'(16'h3000 + beat));
      end
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("bp_released", 32'(lastGrant), 32'h00);

    // Hold limit: requester 3 streams without last while requester 5 waits.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    holdExp = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h20, 8'h00, 8'h08, 8'h08, 8'h00};
    for (int i = 0; i < 11; i++) begin
      setSlice(3, DW'(16'h4000 + i));
      applyStimulus(1'b0, 1'b1, (i < 7) ? 8'h28 : ((i < 10) ? 8'h08 : 8'h00),
                    (i == 9) ? 8'h28 : 8'h20, 1'b1);
      checkOutput($sformatf("hold_grant_%0d", i), 32'(lastGrant), 32'(holdExp[i]));
    end

    // Enable freeze for three cycles in the middle of a three-beat packet from requester 1.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h00, 1'b1);
    setSlice(1, 16'h5001);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h00, 1'b1);
    setSlice(1, 16'h5002);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h02, 8'h02, 1'b1);
      checkOutput($sformatf("freeze_grant_%0d", i), 32'(lastGrant), 32'h02);
    end
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h00, 1'b1);
    setSlice(1, 16'h5003);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h02, 1'b1);
    checkOutput("freeze_last_beat", 32'(lastGrant), 32'h02);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("freeze_released", 32'(lastGrant), 32'h00);

    // Wrap from requester 7 to 0, then reset mid-grant must restart the scan at 0.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h40, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b1);
    checkOutput("wrap_grant_7", 32'(lastGrant), 32'h80);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b1);
    checkOutput("wrap_grant_0", 32'(lastGrant), 32'h01);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b0);
    checkOutput("wrap_grant_7_again", 32'(lastGrant), 32'h80);
    applyStimulus(1'b1, 1'b1, 8'h81, 8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b0);
    checkOutput("midlock_rst_grant", 32'(lastGrant), 32'h00);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'hFF, 1'b0);
    checkOutput("post_rst_ptr0", 32'(lastGrant), 32'h01);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) setSlice(k, DW'($urandom));
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 7) != 0,
                    N'($urandom) & N'($urandom | $urandom),
                    N'($urandom) & N'($urandom),
                    $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
